instruction_fetch_unit: RTL
===========================

// Module: instruction_fetch_unit
// PURPOSE
//  Fetch/decode front end that reads the combinational 28-bit program ROM. Owns the PC,
//  drives the ROM address, splits each returned word into fields for the execute stage,
//  resolves JMP locally and flushes on BLE redirects from execute. Sits between ROM and ALU/register file.
// PARAMETERS
//  PC_W      16        PC/ROM address width
//  RESET_PC  16'd0     PC value loaded on reset
//  OPC_W     4         opcode field width; opcode = instr[27:24]
// PORTS
//  Clock           in   1      system clock, rising edge
//  Reset           in   1      asynchronous, active-high
//  oAddress        out  PC_W   ROM address (= PC register, no comb. path from ROM)
//  iInstruction    in   28     ROM word for oAddress, valid same cycle
//  iStall          in   1      execute cannot accept; hold PC and decode register
//  iBranchTaken    in   1      execute resolved taken BLE this cycle
//  iBranchTarget   in   8      BLE target (zero-extended to PC_W)
//  oValid          out  1      decode register holds an issuable instruction
//  oOpcode         out  OPC_W  instr[27:24]
//  oDest           out  8      instr[23:16]
//  oSrcA           out  8      instr[15:8]
//  oSrcB           out  8      instr[7:0]
//  oImm            out  16     instr[15:0]
//  oPC             out  PC_W   address the decoded instruction came from
// BEHAVIOUR
//  - Reset (async): PC=RESET_PC, state=FLUSH, oValid=0, all field outputs 0, oPC=0.
//  - FSM: FLUSH -> RUN (one cycle after reset, or after any redirect); RUN stays RUN.
//    FLUSH: oValid<=0, PC held; absorbs the cycle in which a redirect address reaches the ROM.
//  - RUN, no stall/redirect: decode reg <= fields of iInstruction, oPC<=PC, oValid<=1,
//    PC<=PC+1 (wraps 16'hFFFF->0). Latency ROM word -> outputs: 1 clock.
//  - JMP decoded from iInstruction in RUN: not issued (oValid<=0), PC<=instr[23:16]
//    zero-extended, stays RUN (target already on oAddress next cycle).
//  - BLE issued normally; fetch continues at PC+1 (predict not-taken).
//  - iBranchTaken=1: PC<=iBranchTarget, oValid<=0, state<=FLUSH; wrong-path word discarded.
//  - iStall=1 (no redirect): PC, decode reg, oValid all hold; JMP in ROM word not acted on.
//  - Priority: Reset > iBranchTaken > iStall > JMP > sequential.
//  - Any opcode not defined in the shared definitions is issued unchanged; execute treats it as NOP.
//  - Reset mid-stall/mid-redirect: async clear wins; fetch restarts at RESET_PC after one FLUSH cycle.
// STRUCTURE
//  - Opcode constants (NOP, LED, STO, ADD, SUB, BLE, JMP) and field bit ranges come from
//    the shared definitions include; no local opcode literals.
//  - One sub-module: fetch_pc_next (comb next-PC mux: seq/jmp/branch/hold).
//  - FSM state encoding: localparam in this file (2 states).
// TESTING
//  1. Reset high 3 cycles, release: oAddress=0,0,1,2...; oValid first 1 two clocks after release.
//  2. ROM {ADD,R1,R1,R3} at 8: next cycle oOpcode=ADD,oDest=1,oSrcA=1,oSrcB=3,oPC=8.
//  3. ROM {JMP,8'd2,16'b0} at 14: oValid=0 for that slot, oAddress=2 next clock, no PC 15 fetch.
//  4. BLE at 9, iBranchTaken=1,iBranchTarget=8 the following cycle: addr 10 word dropped,
//     one FLUSH bubble, next valid oPC=8.
//  5. iStall held 4 cycles mid-stream: oAddress, oOpcode, oPC, oValid unchanged; resume at PC+1.
//  6. iStall and iBranchTaken same cycle: redirect wins. PC at 16'hFFFF: next fetch address is 0.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch/decode front end.
// Holds the 28-bit instruction word layout, the opcode constants and the
// next-PC select encoding used between the top and fetch_pc_next.
// No ports (package).
package instruction_fetch_unit_pkg;

  localparam int INSTR_W = 28;

  // Instruction word layout: {opcode, dest, srca, srcb}. Imm overlays srca/srcb.
  localparam int OPC_HI  = 27;
  localparam int OPC_LO  = 24;
  localparam int DEST_HI = 23;
  localparam int DEST_LO = 16;
  localparam int SRCA_HI = 15;
  localparam int SRCA_LO = 8;
  localparam int SRCB_HI = 7;
  localparam int SRCB_LO = 0;
  localparam int IMM_HI  = 15;
  localparam int IMM_LO  = 0;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LED = 4'h1;
  localparam logic [3:0] OP_STO = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_BLE = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;

  // Next-PC source select.
  typedef enum logic [1:0] {
    PC_HOLD   = 2'd0,
    PC_SEQ    = 2'd1,
    PC_JMP    = 2'd2,
    PC_BRANCH = 2'd3
  } pc_sel_e;

  function automatic logic [3:0] instr_opcode(input logic [INSTR_W-1:0] w);
    return w[OPC_HI:OPC_LO];
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_pc_next.sv
// fetch_pc_next: combinational next-PC multiplexer for the fetch unit.
// Ports:
//   sel           in  pc_sel_e  hold / sequential / jump / branch select
//   pc            in  PC_W      current PC
//   jmp_target    in  8         JMP target from instr[23:16]
//   branch_target in  8         BLE target from execute
//   pc_next       out PC_W      PC for the next cycle
module fetch_pc_next
  import instruction_fetch_unit_pkg::*;
#(
  parameter int PC_W = 16
) (
  input  pc_sel_e         sel,
  input  logic [PC_W-1:0] pc,
  input  logic [7:0]      jmp_target,
  input  logic [7:0]      branch_target,
  output logic [PC_W-1:0] pc_next
);

  always_comb begin
    pc_next = pc;
    case (sel)
      PC_SEQ:    pc_next = pc + PC_W'(1);        // wraps at the top of the space
      PC_JMP:    pc_next = PC_W'(jmp_target);    // zero-extended
      PC_BRANCH: pc_next = PC_W'(branch_target); // zero-extended
      default:   pc_next = pc;
    endcase
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: fetch/decode front end for the 28-bit program ROM.
// Owns the PC, addresses the combinational ROM, registers the returned word as
// decoded fields, resolves JMP locally and flushes on BLE redirects.
// Ports:
//   Clock, Reset          clock (rising edge), asynchronous active-high reset
//   oAddress              ROM address, straight from the PC register
//   iInstruction          ROM word for oAddress, valid in the same cycle
//   iStall                execute cannot accept this cycle
//   iBranchTaken          execute resolved a taken BLE this cycle
//   iBranchTarget         BLE target, zero-extended to PC_W
//   oValid                decode register holds an issuable instruction
//   oOpcode/oDest/oSrcA/oSrcB/oImm  decoded fields
//   oPC                   address the decoded instruction came from
//   oDbgState             FSM state (0 = FLUSH, 1 = RUN)
//
// Handshake: oValid qualifies every decoded field. Execute takes the decoded
// instruction on any cycle where oValid=1 and iStall=0; while iStall=1 the
// decode register and PC hold. iBranchTaken overrides iStall and discards
// whatever is in flight.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              OPC_W    = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  output logic [PC_W-1:0]  oAddress,
  input  logic [27:0]      iInstruction,
  input  logic             iStall,
  input  logic             iBranchTaken,
  input  logic [7:0]       iBranchTarget,
  output logic             oValid,
  output logic [OPC_W-1:0] oOpcode,
  output logic [7:0]       oDest,
  output logic [7:0]       oSrcA,
  output logic [7:0]       oSrcB,
  output logic [15:0]      oImm,
  output logic [PC_W-1:0]  oPC,
  output logic             oDbgState
);

  // FLUSH absorbs the cycle in which a new (reset or redirect) address is
  // first presented to the ROM; RUN fetches every cycle.
  typedef enum logic {
    ST_FLUSH = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [PC_W-1:0]        pc_q, pc_next;
  logic [INSTR_W-1:0]     dec_q;
  logic [PC_W-1:0]        pc_dec_q;
  logic                   valid_q, valid_d;
  logic                   load_dec;
  pc_sel_e                pc_sel;
  logic                   is_jmp;

  assign is_jmp = (instr_opcode(iInstruction) == OP_JMP);

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    pc_sel   = PC_HOLD;
    load_dec = 1'b0;
    if (iBranchTaken) begin
      // Wrong-path word on the ROM bus is dropped; target reaches ROM next cycle.
      pc_sel  = PC_BRANCH;
      valid_d = 1'b0;
      state_d = ST_FLUSH;
    end else if (state_q == ST_FLUSH) begin
      valid_d = 1'b0;
      state_d = ST_RUN;
    end else if (iStall) begin
      pc_sel = PC_HOLD;
    end else if (is_jmp) begin
      // The jump target is on oAddress next cycle, so no bubble state is needed.
      pc_sel  = PC_JMP;
      valid_d = 1'b0;
    end else begin
      pc_sel   = PC_SEQ;
      valid_d  = 1'b1;
      load_dec = 1'b1;
    end
  end

  fetch_pc_next #(
    .PC_W (PC_W)
  ) u_pc_next (
    .sel           (pc_sel),
    .pc            (pc_q),
    .jmp_target    (iInstruction[DEST_HI:DEST_LO]),
    .branch_target (iBranchTarget),
    .pc_next       (pc_next)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= ST_FLUSH;
      pc_q     <= RESET_PC;
      valid_q  <= 1'b0;
      dec_q    <= '0;
      pc_dec_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_next;
      valid_q <= valid_d;
      if (load_dec) begin
        dec_q    <= iInstruction;
        pc_dec_q <= pc_q;
      end
    end
  end

  assign oAddress  = pc_q;
  assign oValid    = valid_q;
  assign oOpcode   = OPC_W'(dec_q[OPC_HI:OPC_LO]);
  assign oDest     = dec_q[DEST_HI:DEST_LO];
  assign oSrcA     = dec_q[SRCA_HI:SRCA_LO];
  assign oSrcB     = dec_q[SRCB_HI:SRCB_LO];
  assign oImm      = dec_q[IMM_HI:IMM_LO];
  assign oPC       = pc_dec_q;
  assign oDbgState = state_q;

endmodule
